light_sched_ctrl: RTL and testbench

Controller that shares one room light between N_SW wall push-buttons. Each raw button is synchronised and debounced. Each debounced press becomes a pending toggle request, and a round-robin arbiter grants at most one request per cycle. A 3-state FSM drives the light and adds an auto-off timeout with a blinking warning phase.

---
 rtl/light_ctrl_pkg.sv | 22 ++
 rtl/light_sched_ctrl_debounce.sv | 48 ++++
 rtl/light_sched_ctrl.sv | 160 ++++++++++++++++
 tb/tb_light_sched_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/light_ctrl_pkg.sv
// Shared types and width helpers for the shared-room-light scheduler.
package light_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_ON   = 2'd1,
        ST_WARN = 2'd2
    } state_t;

    // Bits needed to hold values 0..v-1; never less than 1 so degenerate parameters still elaborate.
    function automatic int clog2w(input int v);
        int r;
        r = 1;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/light_sched_ctrl_debounce.sv
// One wall button: two-flop synchroniser, hold-time debouncer and a one-cycle press pulse.
module sw_debounce
    import light_ctrl_pkg::*;
#(
    parameter int DEB_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_press
);

    localparam int CW = clog2w(DEB_CYC);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYC - 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_deb;
    logic [CW-1:0] r_cnt;
    logic          r_press;

    // The press pulse is raised on the same edge the debounced level rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_deb   <= 1'b0;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_s1    <= i_raw;
            r_s2    <= r_s1;
            r_press <= 1'b0;
            if (r_s2 == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_deb   <= r_s2;
                r_cnt   <= '0;
                r_press <= r_s2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/light_sched_ctrl.sv
// Shared room light: debounced buttons queue toggle requests, a round-robin arbiter
// accepts one per cycle, and an OFF/ON/WARN FSM adds auto-off with a blinking warning.
module light_sched_ctrl
    import light_ctrl_pkg::*;
#(
    parameter int N_SW        = 4,
    parameter int DEB_CYC     = 16,
    parameter int TIMEOUT_CYC = 1000,
    parameter int WARN_CYC    = 100,
    parameter int BLINK_HALF  = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_SW-1:0] sw_raw,
    input  logic            force_off,
    output logic            light,
    output logic [N_SW-1:0] grant,
    output logic [1:0]      state
);

    localparam int TW = clog2w(max2(TIMEOUT_CYC, WARN_CYC));
    localparam int PW = clog2w(N_SW);
    localparam int BW = clog2w(BLINK_HALF);
    localparam logic [TW-1:0] T_LOAD = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] W_LOAD = TW'(WARN_CYC - 1);
    localparam logic [BW-1:0] B_MAX  = BW'(BLINK_HALF - 1);
    localparam logic [N_SW-1:0] ONE  = {{(N_SW-1){1'b0}}, 1'b1};

    logic [N_SW-1:0] w_press;
    logic [N_SW-1:0] r_pend;
    logic [PW-1:0]   r_ptr;
    logic [N_SW-1:0] r_grant;
    state_t          r_state;
    logic            r_light;
    logic [TW-1:0]   r_timer;
    logic            r_phase;
    logic [BW-1:0]   r_bcnt;

    logic            w_found;
    logic [PW-1:0]   w_idx;
    logic [PW-1:0]   w_sel_idx;
    logic [N_SW-1:0] w_sel;
    logic            w_gnt_v;
    logic [N_SW-1:0] w_pend_n;
    logic [PW-1:0]   w_ptr_n;
    state_t          w_state_n;
    logic [TW-1:0]   w_timer_n;
    logic            w_phase_n;
    logic [BW-1:0]   w_bcnt_n;
    logic            w_light_n;

    for (genvar g = 0; g < N_SW; g++) begin : g_deb
        sw_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
            .clk     (clk),
            .rst     (rst),
            .i_raw   (sw_raw[g]),
            .o_press (w_press[g])
        );
    end

    // Round-robin pick: first pending bit at or above the pointer, wrapping.
    always_comb begin
        w_found   = 1'b0;
        w_idx     = '0;
        w_sel_idx = '0;
        for (int k = 0; k < N_SW; k++) begin
            w_idx = PW'((int'(r_ptr) + k) % N_SW);
            if (!w_found && r_pend[w_idx]) begin
                w_found   = 1'b1;
                w_sel_idx = w_idx;
            end
        end
        w_sel   = w_found ? (ONE << w_sel_idx) : '0;
        w_gnt_v = w_found && !force_off;
        w_ptr_n = w_gnt_v ? PW'((int'(w_sel_idx) + 1) % N_SW) : r_ptr;
        if (force_off)
            w_pend_n = '0;
        else
            w_pend_n = (r_pend & ~(w_gnt_v ? w_sel : '0)) | w_press;
    end

    always_comb begin
        w_state_n = r_state;
        w_timer_n = r_timer;
        w_phase_n = r_phase;
        w_bcnt_n  = r_bcnt;
        case (r_state)
            ST_OFF: begin
                if (w_gnt_v) begin
                    w_state_n = ST_ON;
                    w_timer_n = T_LOAD;
                end
            end
            ST_ON: begin
                if (w_gnt_v) begin
                    w_state_n = ST_OFF;
                end else if (r_timer == '0) begin
                    w_state_n = ST_WARN;
                    w_timer_n = W_LOAD;
                    w_phase_n = 1'b0;
                    w_bcnt_n  = '0;
                end else begin
                    w_timer_n = r_timer - 1'b1;
                end
            end
            ST_WARN: begin
                if (r_bcnt == B_MAX) begin
                    w_bcnt_n  = '0;
                    w_phase_n = ~r_phase;
                end else begin
                    w_bcnt_n = r_bcnt + 1'b1;
                end
                // A press during the warning re-arms the full timeout.
                if (w_gnt_v) begin
                    w_state_n = ST_ON;
                    w_timer_n = T_LOAD;
                end else if (r_timer == '0) begin
                    w_state_n = ST_OFF;
                end else begin
                    w_timer_n = r_timer - 1'b1;
                end
            end
            default: w_state_n = ST_OFF;
        endcase
        if (force_off)
            w_state_n = ST_OFF;
        case (w_state_n)
            ST_ON:   w_light_n = 1'b1;
            ST_WARN: w_light_n = w_phase_n;
            default: w_light_n = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend  <= '0;
            r_ptr   <= '0;
            r_grant <= '0;
            r_state <= ST_OFF;
            r_light <= 1'b0;
            r_timer <= '0;
            r_phase <= 1'b0;
            r_bcnt  <= '0;
        end else begin
            r_pend  <= w_pend_n;
            r_ptr   <= w_ptr_n;
            r_grant <= w_gnt_v ? w_sel : '0;
            r_state <= w_state_n;
            r_light <= w_light_n;
            r_timer <= w_timer_n;
            r_phase <= w_phase_n;
            r_bcnt  <= w_bcnt_n;
        end
    end

    assign light = r_light;
    assign grant = r_grant;
    assign state = r_state;

endmodule

// File: tb/tb_light_sched_ctrl.sv
// Directed bench for light_sched_ctrl: cycle table for a single press plus hand sequences.
module tb_light_sched_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] sw_raw;
    logic       force_off;
    logic       light;
    logic [3:0] grant;
    logic [1:0] state;

    int n_tests;
    int n_fail;
    int cyc;

    typedef struct {
        logic [3:0] sw;
        logic       fo;
        logic [3:0] grant;
        logic       light;
        logic [1:0] state;
    } vec_t;

    vec_t tbl [12];

    light_sched_ctrl #(
        .N_SW(4), .DEB_CYC(4), .TIMEOUT_CYC(20), .WARN_CYC(8), .BLINK_HALF(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw_raw    (sw_raw),
        .force_off (force_off),
        .light     (light),
        .grant     (grant),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_until(input int n);
        while (cyc < n) tick();
    endtask

    task automatic do_reset();
        sw_raw    = '0;
        force_off = 1'b0;
        rst       = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        cyc = 0;
    endtask

    // Hold mask from edge 1; grant must stay quiet through edge 7, then g1 at edge 8 and g2 at edge 9.
    task automatic press_expect(input logic [3:0] mask, input logic [3:0] g1, input logic [3:0] g2);
        sw_raw = mask;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("quiet_before_grant", grant, 0);
        end
        tick();
        chk("first_grant", grant, g1);
        tick();
        chk("second_grant", grant, g2);
    endtask

    int gcount;

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        cyc       = 0;
        sw_raw    = '0;
        force_off = 1'b0;
        rst       = 1'b1;
        #1;
        chk("reset_light", light, 0);
        chk("reset_grant", grant, 0);
        chk("reset_state", state, 0);

        for (int r = 1; r <= 12; r++) begin
            tbl[r-1].sw    = (r <= 10) ? 4'b0100 : 4'b0000;
            tbl[r-1].fo    = 1'b0;
            tbl[r-1].grant = (r == 8) ? 4'b0100 : 4'b0000;
            tbl[r-1].light = (r >= 8);
            tbl[r-1].state = (r >= 8) ? 2'd1 : 2'd0;
        end

        // Single press on switch 2
        do_reset();
        for (int i = 0; i < 12; i++) begin
            sw_raw    = tbl[i].sw;
            force_off = tbl[i].fo;
            tick();
            chk("t1_grant", grant, tbl[i].grant);
            chk("t1_light", light, tbl[i].light);
            chk("t1_state", state, tbl[i].state);
        end

        // Bounce that settles low: never a grant
        do_reset();
        for (int i = 0; i < 24; i++) begin
            sw_raw = (i < 12 && (i % 4) < 2) ? 4'b0001 : 4'b0000;
            tick();
            chk("t2_low_grant", grant, 0);
            chk("t2_low_light", light, 0);
        end
        // Bounce that settles high: exactly one grant
        do_reset();
        gcount = 0;
        for (int i = 0; i < 28; i++) begin
            sw_raw = (i >= 12 || (i % 4) < 2) ? 4'b0001 : 4'b0000;
            tick();
            if (grant != 0) gcount++;
        end
        chk("t2_high_grants", gcount, 1);
        chk("t2_high_light", light, 1);

        // Simultaneous presses on 1 and 3, then on 0 and 3 to show the pointer wrapped to 0
        do_reset();
        press_expect(4'b1010, 4'b0010, 4'b1000);
        chk("t3_light_after", light, 0);
        chk("t3_state_after", state, 0);
        sw_raw = '0;
        for (int i = 0; i < 10; i++) tick();
        press_expect(4'b1001, 4'b0001, 4'b1000);
        chk("t3b_light_after", light, 0);
        sw_raw = '0;

        // Timeout: 20 cycles ON, 8 cycles WARN blinking, then OFF
        do_reset();
        press_expect(4'b0001, 4'b0001, 4'b0000);
        sw_raw = '0;
        while (cyc < 27) begin
            tick();
            chk("t4_on_state", state, 1);
            chk("t4_on_light", light, 1);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t4_warn_state", state, 2);
            chk("t4_warn_light", light, ((i % 4) >= 2) ? 1 : 0);
        end
        tick();
        chk("t4_off_state", state, 0);
        chk("t4_off_light", light, 0);

        // Extend: grant lands at the edge ending WARN cycle 3
        do_reset();
        press_expect(4'b0010, 4'b0010, 4'b0000);
        sw_raw = '0;
        run_until(23);
        sw_raw = 4'b0010;
        run_until(27);
        chk("t5_pre_state", state, 1);
        tick();
        chk("t5_w1_state", state, 2);
        chk("t5_w1_light", light, 0);
        tick();
        chk("t5_w2_light", light, 0);
        tick();
        chk("t5_w3_state", state, 2);
        chk("t5_w3_light", light, 1);
        tick();
        chk("t5_ext_grant", grant, 4'b0010);
        chk("t5_ext_state", state, 1);
        chk("t5_ext_light", light, 1);
        sw_raw = '0;
        run_until(50);
        chk("t5_still_on", state, 1);
        tick();
        chk("t5_new_warn", state, 2);

        // force_off on the edge where pending[1] would be set
        do_reset();
        press_expect(4'b0001, 4'b0001, 4'b0000);
        sw_raw = '0;
        run_until(11);
        sw_raw = 4'b0010;
        run_until(17);
        chk("t6_pre_light", light, 1);
        force_off = 1'b1;
        tick();
        force_off = 1'b0;
        chk("t6_fo_state", state, 0);
        chk("t6_fo_light", light, 0);
        chk("t6_fo_grant", grant, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_lost_grant", grant, 0);
            chk("t6_lost_state", state, 0);
        end
        sw_raw = '0;

        // Asynchronous reset in the middle of WARN while the light is lit
        do_reset();
        press_expect(4'b0100, 4'b0100, 4'b0000);
        sw_raw = '0;
        run_until(30);
        chk("t7_pre_state", state, 2);
        chk("t7_pre_light", light, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t7_async_light", light, 0);
        chk("t7_async_state", state, 0);
        chk("t7_async_grant", grant, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t7_post_grant", grant, 0);
            chk("t7_post_state", state, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
